// File: rtl/processing_element_os_multi_acc.sv
// Output-stationary systolic PE: signed MAC into banked accumulators plus a
// handshaked post-op FSM (bias/relu/leaky/load). PE_SATURATE_EN enables clamping.
module processing_element_os_multi_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_ACC    = 4,
  parameter int ALPHA_FRAC = 8
) (
  input  logic                         core_clk,
  input  logic                         resetn,
  input  logic                         pulse_systolic_module,
  input  logic [$clog2(NUM_ACC)-1:0]   mac_acc_sel,
  input  logic                         pe_forward_in_valid,
  input  logic [DATA_WIDTH-1:0]        pe_forward_in,
  input  logic                         pe_down_in_valid,
  input  logic [DATA_WIDTH-1:0]        pe_down_in,
  output logic                         pe_forward_out_valid,
  output logic [DATA_WIDTH-1:0]        pe_forward_out,
  output logic                         pe_down_out_valid,
  output logic [DATA_WIDTH-1:0]        pe_down_out,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [1:0]                   op_code,
  input  logic [$clog2(NUM_ACC)-1:0]   op_acc_sel,
  input  logic [ACC_WIDTH-1:0]         op_data,
  input  logic [DATA_WIDTH-1:0]        leaky_alpha,
  input  logic [$clog2(NUM_ACC)-1:0]   rd_sel,
  output logic [ACC_WIDTH-1:0]         rd_data,
  output logic                         collision_err,
  output logic [31:0]                  debug_update_counter
);

  localparam int SW = $clog2(NUM_ACC);
  localparam int PW = ACC_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_WB
  } state_e;

  typedef enum logic [1:0] {
    OP_BIAS, OP_RELU, OP_LEAKY, OP_LOAD
  } op_e;

  state_e state_q, state_d;
  op_e    code_q;
  logic [SW-1:0]         sel_q;
  logic [ACC_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0] alpha_q;
  logic [ACC_WIDTH-1:0]  res_q, res_d;

  logic [ACC_WIDTH-1:0]  acc_q [NUM_ACC];
  logic [ACC_WIDTH-1:0]  acc_d [NUM_ACC];

  logic                  fv_q, dv_q;
  logic [DATA_WIDTH-1:0] f_q, d_q;
  logic                  err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  mac_en, accept, wb, hit;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  mac_old, mac_sum;
  logic [ACC_WIDTH-1:0]  acc_rd, bias_sum, leaky_res;
  logic signed [PW-1:0]  lk_prod;

  assign mac_en = pulse_systolic_module
                & pe_forward_in_valid
                & pe_down_in_valid;
  assign accept = op_valid & op_ready;
  assign wb     = (state_q == S_WB);
  assign hit    = wb & mac_en & (mac_acc_sel == sel_q);

  assign prod    = $signed(pe_forward_in) * $signed(pe_down_in);
  assign mac_old = acc_q[mac_acc_sel];
  assign acc_rd  = acc_q[sel_q];
  assign lk_prod = PW'($signed(acc_rd))
                 * PW'($signed({1'b0, alpha_q}));

`ifdef PE_SATURATE_EN
  localparam logic signed [PW-1:0] SMAX =
    {{(PW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  function automatic logic [ACC_WIDTH-1:0] clamp(
    input logic signed [PW-1:0] v
  );
    if (v > SMAX) return SMAX[ACC_WIDTH-1:0];
    if (v < SMIN) return SMIN[ACC_WIDTH-1:0];
    return v[ACC_WIDTH-1:0];
  endfunction

  assign mac_sum   = clamp(PW'($signed(mac_old)) + PW'(prod));
  assign bias_sum  = clamp(PW'($signed(acc_rd))
                         + PW'($signed(data_q)));
  assign leaky_res = clamp(lk_prod >>> ALPHA_FRAC);
`else
  assign mac_sum   = mac_old + ACC_WIDTH'(prod);
  assign bias_sum  = acc_rd + data_q;
  assign leaky_res = ACC_WIDTH'(lk_prod >>> ALPHA_FRAC);
`endif

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    res_d = res_q;
    unique case (1'b1)
      (code_q == OP_BIAS):  res_d = bias_sum;
      (code_q == OP_RELU):
        res_d = acc_rd[ACC_WIDTH-1] ? '0 : acc_rd;
      (code_q == OP_LEAKY):
        res_d = acc_rd[ACC_WIDTH-1] ? leaky_res : acc_rd;
      (code_q == OP_LOAD):  res_d = data_q;
      default: ;
    endcase
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      code_q  <= OP_BIAS;
      sel_q   <= '0;
      data_q  <= '0;
      alpha_q <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        code_q  <= op_e'(op_code);
        sel_q   <= op_acc_sel;
        data_q  <= op_data;
        alpha_q <= leaky_alpha;
      end
      if (state_q == S_EXEC) res_q <= res_d;
    end
  end

  // op write-back is applied last so it wins over a same-bank MAC
  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) acc_d[i] = acc_q[i];
    if (mac_en) acc_d[mac_acc_sel] = mac_sum;
    if (wb)     acc_d[sel_q] = res_q;
  end

  assign err_d = err_q | hit;
  assign cnt_d = cnt_q + {31'b0, mac_en};

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_d[i];
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      fv_q <= 1'b0;
      dv_q <= 1'b0;
      f_q  <= '0;
      d_q  <= '0;
    end else if (pulse_systolic_module) begin
      fv_q <= pe_forward_in_valid;
      dv_q <= pe_down_in_valid;
      f_q  <= pe_forward_in;
      d_q  <= pe_down_in;
    end
  end

  assign pe_forward_out_valid = fv_q;
  assign pe_forward_out       = f_q;
  assign pe_down_out_valid    = dv_q;
  assign pe_down_out          = d_q;
  assign rd_data              = acc_q[rd_sel];
  assign collision_err        = err_q;
  assign debug_update_counter = cnt_q;

endmodule
